// File: rtl/core_pkg.sv
// Shared core-wide sizes and the register-file address/data types.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned REG_ADDR_W = $clog2(REG_NUM);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       reg_data_t;

  // Address width for a table of n entries; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_id_scoreboard.sv
// In-flight destination scoreboard: one busy bit per architectural register,
// set at issue (alloc), cleared at writeback, with a zero-latency per-read-port
// lookup that already accounts for a writeback landing in the same cycle.
module core_id_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NUM_REGS = REG_NUM,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_REGS-1:0]      busy_vec
);

  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W-1:0]   wr_idx [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;
  logic [ADDR_W-1:0]   rd_idx [NUM_RD];
  logic [NUM_RD-1:0]   rd_ok;
  logic [NUM_RD-1:0]   rd_hit;
  logic                alloc_ok;

  // Register 0 and out-of-range addresses never participate in tracking.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wr_idx[w] = wr_addr[w*ADDR_W +: ADDR_W];
    assign wr_ok[w]  = wr_en[w] && (wr_idx[w] != '0) && ({1'b0, wr_idx[w]} < ADDR_LIM);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_idx[i] = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_ok[i]  = (rd_idx[i] != '0) && ({1'b0, rd_idx[i]} < ADDR_LIM);
  end

  assign alloc_ok = alloc_en && (alloc_addr != '0) && ({1'b0, alloc_addr} < ADDR_LIM);

  // Next busy state: writebacks clear first, then alloc sets so a new
  // producer issued in the same cycle as the old one retires stays tracked.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_ok[w]) busy_nxt[wr_idx[w]] = 1'b0;
    end
    if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
  end

  // Busy bit storage, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Flag read ports whose register is being written back this very cycle.
  always_comb begin
    rd_hit = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w] && (wr_idx[w] == rd_idx[i])) rd_hit[i] = 1'b1;
      end
    end
  end

  // Zero-latency busy lookup; a same-cycle alloc is deliberately not visible.
  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (rd_ok[i]) rd_busy[i] = busy[rd_idx[i]] && !rd_hit[i];
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/core_id_reg_file_sb.sv
// Decode-stage register file with write-through bypass and an attached
// in-flight scoreboard. Register 0 is hardwired to zero.
module core_id_reg_file_sb
  import core_pkg::*;
#(
  parameter  int unsigned DATA_W   = XLEN,
  parameter  int unsigned NUM_REGS = REG_NUM,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned NUM_WR   = 2,
  localparam int unsigned ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs   [NUM_REGS];
  logic [ADDR_W-1:0] wr_idx [NUM_WR];
  logic [DATA_W-1:0] wr_val [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic [ADDR_W-1:0] rd_idx [NUM_RD];
  logic [NUM_RD-1:0] rd_ok;

  // rst_n gates wr_ok so the bypass cannot leak write data while in reset.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wr_idx[w] = wr_addr[w*ADDR_W +: ADDR_W];
    assign wr_val[w] = wr_data[w*DATA_W +: DATA_W];
    assign wr_ok[w]  = rst_n && wr_en[w] && (wr_idx[w] != '0)
                       && ({1'b0, wr_idx[w]} < ADDR_LIM);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_idx[i] = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_ok[i]  = (rd_idx[i] != '0) && ({1'b0, rd_idx[i]} < ADDR_LIM);
  end

  // Register array; later write ports are applied last so they win collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) regs[wr_idx[w]] <= wr_val[w];
      end
    end
  end

  // Combinational read with write-through bypass; highest write port wins.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (rd_ok[i]) rd_data[i*DATA_W +: DATA_W] = regs[rd_idx[i]];
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w] && (wr_idx[w] == rd_idx[i])) rd_data[i*DATA_W +: DATA_W] = wr_val[w];
      end
    end
  end

  core_id_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .busy_vec   (busy_vec)
  );

endmodule

// File: doc/core_id_reg_file_sb.md
CORE_ID_REG_FILE_SB -- requirements
Module: core_id_reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the register count; ADDR_W = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2, SHALL set the read port count (1..4).
REQ-004 Parameter NUM_WR, default 2, SHALL set the write port count (1..2).
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-007 rd_addr  in  NUM_RD*ADDR_W  SHALL carry the read addresses; port i uses slice i.
REQ-008 rd_data  out  NUM_RD*DATA_W  SHALL carry the read data per port.
REQ-009 rd_busy  out  NUM_RD  SHALL flag that the addressed register has a pending write.
REQ-010 wr_en  in  NUM_WR  SHALL carry the writeback strobes.
REQ-011 wr_addr  in  NUM_WR*ADDR_W  SHALL carry the writeback addresses.
REQ-012 wr_data  in  NUM_WR*DATA_W  SHALL carry the writeback data.
REQ-013 alloc_en  in  1  SHALL mark a new in-flight destination at issue.
REQ-014 alloc_addr  in  ADDR_W  SHALL carry the destination being allocated.
REQ-015 busy_vec  out  NUM_REGS  SHALL expose the registered scoreboard bits.

Function
REQ-016 Register 0 SHALL read as 0 always; writes and allocs to address 0 SHALL be ignored.
REQ-017 Reads SHALL be combinational: rd_data[i] = regs[rd_addr[i]], zero latency.
REQ-018 Write-through bypass SHALL apply: a same-cycle wr_en to rd_addr[i] (nonzero) SHALL drive its wr_data onto rd_data[i].
REQ-019 A write SHALL update regs on the next rising edge; visible from the array one cycle after the strobe.
REQ-020 Two write ports hitting the same address SHALL resolve to the higher port index, for both the array and the bypass.
REQ-021 Scoreboard: alloc_en SHALL set busy[alloc_addr] on the next edge.
REQ-022 A wr_en SHALL clear busy[wr_addr] on the next edge.
REQ-023 Simultaneous alloc and writeback to the same address SHALL leave busy set (alloc wins: new producer in flight).
REQ-024 rd_busy[i] SHALL be busy[rd_addr[i]] AND NOT (same-cycle wr_en to that address), zero latency; a same-cycle alloc SHALL NOT affect rd_busy.
REQ-025 rd_busy for address 0 SHALL be 0.
REQ-026 Writeback to a non-busy register SHALL be legal: data written, busy unchanged at 0.
REQ-027 Out-of-range addresses (>= NUM_REGS when not a power of two) SHALL read 0; writes and allocs to them are dropped.

Reset
REQ-028 Asserting rst_n low SHALL clear all registers and busy bits immediately, without waiting for a clock edge.
REQ-029 During reset, rd_data SHALL be 0 and rd_busy and busy_vec SHALL be all 0.
REQ-030 Writes and allocs presented while rst_n is low SHALL be discarded; reset taken mid-operation SHALL drop all pending busy bits.
REQ-031 The first update after deassertion SHALL occur on the first rising edge with rst_n high.

Structure
REQ-032 A shared package core_pkg SHALL hold XLEN=32, REG_NUM=32 and the reg_addr_t and reg_data_t typedefs.
REQ-033 The scoreboard SHALL be a sub-module core_id_scoreboard (busy bits, set/clear, rd_busy lookup); the data array and bypass stay in the top.

Verification
REQ-034 Reset, then write x5=0x12345678 on port 0; read x5 on port 1 the same cycle -> 0x12345678 via bypass; next cycle from the array -> same value.
REQ-035 Write x0=0xFFFFFFFF on both ports -> rd_data for x0 = 0 on every port; busy_vec[0]=0.
REQ-036 Same cycle: port0 writes x7=0xA, port1 writes x7=0xB -> bypass shows 0xB; array holds 0xB afterwards.
REQ-037 alloc x3; next cycle rd_busy=1 for x3; writeback x3=0x55 -> rd_busy=0 that cycle, rd_data=0x55; busy_vec[3]=0 afterwards.
REQ-038 alloc x9 and writeback x9 in the same cycle -> busy_vec[9]=1 next cycle.
REQ-039 Fill x1..x31 with nonzero values and allocs; pulse rst_n low mid-cycle -> all rd_data=0 and busy_vec=0 before the next edge.
